// File: rtl/mips_run_ctrl_pkg.sv
// Shared definitions for the MIPS run controller: FSM state encoding and default knobs.
package mips_run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RESET   = 2'd0,
        ST_RUN     = 2'd1,
        ST_HALTED  = 2'd2,
        ST_TIMEOUT = 2'd3
    } runState_t;

    localparam int DEF_RST_CYCLES  = 4;
    localparam int DEF_HALT_REPEAT = 3;
    localparam int DEF_MAX_CYCLES  = 10000;
    localparam int DEF_PC_W        = 32;
    localparam int DEF_CNT_W       = 32;

endpackage

// File: rtl/mips_run_ctrl_if.sv
// Bundle between the run controller and the core/bench side: restart and PC in,
// reset/run gating, completion flags and the RUN cycle count out.
interface mips_run_ctrl_if #(
    parameter int PC_W  = mips_run_ctrl_pkg::DEF_PC_W,
    parameter int CNT_W = mips_run_ctrl_pkg::DEF_CNT_W
);
    logic             restart;
    logic [PC_W-1:0]  pc;
    logic             cpu_reset;
    logic             cpu_run;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] cycle_cnt;

    // The core side owns restart/pc and watches the controller's outputs.
    modport master (
        output restart, pc,
        input  cpu_reset, cpu_run, done, timeout, cycle_cnt
    );

    modport slave (
        input  restart, pc,
        output cpu_reset, cpu_run, done, timeout, cycle_cnt
    );
endinterface

// File: rtl/mips_run_ctrl_run_counter.sv
// Up-counter with synchronous clear (priority over enable) and a flag that is high
// while the count equals LAST.
module run_counter #(
    parameter int           W    = 8,
    parameter logic [W-1:0] LAST = '1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         term_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt_o  = cnt_q;
    assign term_o = (cnt_q == LAST);

endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller for the MIPS core: stretches reset, gates execution, counts RUN
// cycles, and ends the run on a PC self-loop (done) or an exhausted budget (timeout).
module mips_run_ctrl
    import mips_run_ctrl_pkg::*;
#(
    parameter int RST_CYCLES  = DEF_RST_CYCLES,
    parameter int HALT_REPEAT = DEF_HALT_REPEAT,
    parameter int MAX_CYCLES  = DEF_MAX_CYCLES,
    parameter int PC_W        = DEF_PC_W,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic           clk,
    input  logic           reset,
    mips_run_ctrl_if.slave bus
);

    localparam int RST_W = $clog2(RST_CYCLES) + 1;
    localparam int REP_W = $clog2(HALT_REPEAT) + 1;

    runState_t        state_q;
    logic             cpuReset_q;
    logic             cpuRun_q;
    logic             done_q;
    logic             timeout_q;
    logic             prevValid_q;
    logic [PC_W-1:0]  prevPc_q;
    logic [REP_W-1:0] repCnt_q;
    logic [REP_W-1:0] repCnt_d;

    logic [RST_W-1:0] rstCnt;
    logic [CNT_W-1:0] cycleCnt;
    logic             rstTerm;
    logic             cycTerm;
    logic             rstEn;
    logic             rstClr;
    logic             cycEn;
    logic             pcSame;
    logic             haltHit;
    logic             unusedRstCnt;

    // The stretch counter restarts from zero whenever restart is held and is cleared
    // as RUN is entered, so a later restart always gets the full stretch.
    assign rstEn  = (state_q == ST_RESET) && !bus.restart;
    assign rstClr = bus.restart || ((state_q == ST_RESET) && rstTerm);
    assign cycEn  = (state_q == ST_RUN) && !bus.restart;

    run_counter #(
        .W    (RST_W),
        .LAST (RST_W'(RST_CYCLES - 1))
    ) u_rstCounter (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (rstClr),
        .en_i   (rstEn),
        .cnt_o  (rstCnt),
        .term_o (rstTerm)
    );

    run_counter #(
        .W    (CNT_W),
        .LAST (CNT_W'(MAX_CYCLES - 1))
    ) u_cycleCounter (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (bus.restart),
        .en_i   (cycEn),
        .cnt_o  (cycleCnt),
        .term_o (cycTerm)
    );

    assign unusedRstCnt = ^rstCnt;

    // repCnt counts repeats beyond the first sample, so a halt needs HALT_REPEAT-2
    // earlier repeats plus the current matching PC.
    assign pcSame   = prevValid_q && (bus.pc == prevPc_q);
    assign repCnt_d = pcSame ? repCnt_q + REP_W'(1) : '0;
    assign haltHit  = pcSame && (repCnt_q == REP_W'(HALT_REPEAT - 2));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RESET;
            cpuReset_q  <= 1'b1;
            cpuRun_q    <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            prevValid_q <= 1'b0;
            prevPc_q    <= '0;
            repCnt_q    <= '0;
        end else if (bus.restart) begin
            state_q     <= ST_RESET;
            cpuReset_q  <= 1'b1;
            cpuRun_q    <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            prevValid_q <= 1'b0;
            prevPc_q    <= '0;
            repCnt_q    <= '0;
        end else begin
            case (state_q)
                ST_RESET: begin
                    if (rstTerm) begin
                        state_q    <= ST_RUN;
                        cpuReset_q <= 1'b0;
                        cpuRun_q   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    prevPc_q    <= bus.pc;
                    prevValid_q <= 1'b1;
                    repCnt_q    <= repCnt_d;
                    // A halt seen on the budget's last edge still counts as a clean finish.
                    if (haltHit) begin
                        state_q  <= ST_HALTED;
                        cpuRun_q <= 1'b0;
                        done_q   <= 1'b1;
                    end else if (cycTerm) begin
                        state_q   <= ST_TIMEOUT;
                        cpuRun_q  <= 1'b0;
                        timeout_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.cpu_reset = cpuReset_q;
    assign bus.cpu_run   = cpuRun_q;
    assign bus.done      = done_q;
    assign bus.timeout   = timeout_q;
    assign bus.cycle_cnt = cycleCnt;

endmodule
